// File: rtl/ext_feeder.sv
// Host-side feeder for the pico core's external input: FIFO-buffers host words and
// presents each on ext_data_o with a rising edge on ext_int_o. Optional: EXT_FEEDER_ECHO_EN.
module ext_feeder #(
    parameter int unsigned N         = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PULSE_LEN = 2,
    parameter int unsigned GAP       = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N-1:0]               host_data_i,
    input  logic                       host_valid_i,
    output logic                       host_ready_o,
    input  logic                       halt_i,
    output logic [N-1:0]               ext_data_o,
    output logic                       ext_int_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef EXT_FEEDER_ECHO_EN
    ,
    input  logic [N-1:0]               result_i,
    output logic [N-1:0]               echo_o,
    output logic                       echo_valid_o
`endif
);

    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned TMAX = (PULSE_LEN > GAP) ? PULSE_LEN : GAP;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          load;
    logic          pop;
    logic          push;
    logic          int_next;

    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Ready depends only on the registered count, so a pop cannot make room in the same cycle.
    assign host_ready_o = (count_o != CW'(DEPTH)) & ~rst_i;
    assign push         = host_valid_i & host_ready_o;
    assign busy_o       = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        load       = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if ((count_o != '0) && !halt_i) begin
                    load       = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = PULSE;
                timer_next = '0;
            end
            PULSE: begin
                if (timer == TW'(PULSE_LEN - 1)) begin
                    state_next = HOLD;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            HOLD: begin
                if (timer == TW'(GAP - 1)) begin
                    state_next = IDLE;
                    timer_next = '0;
                    pop        = 1'b1;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // Registered next-state decode keeps ext_int_o glitch-free and aligned with PULSE.
        int_next = (state_next == PULSE);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= host_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_o    <= '0;
            ext_data_o <= '0;
            ext_int_o  <= 1'b0;
        end else begin
            ext_int_o <= int_next;
            if (load) begin
                ext_data_o <= mem[rd_ptr];
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_o <= count_o + CW'(1);
                2'b01:   count_o <= count_o - CW'(1);
                default: count_o <= count_o;
            endcase
        end
    end

`ifdef EXT_FEEDER_ECHO_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            echo_o       <= '0;
            echo_valid_o <= 1'b0;
        end else begin
            echo_valid_o <= pop;
            if (pop) begin
                echo_o <= result_i;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ext_feeder.sv
// Directed self-checking bench for ext_feeder; echo checks compile in with EXT_FEEDER_ECHO_EN.
module tb_ext_feeder;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  hd;
    logic          hv;
    logic          ready;
    logic          halt;
    logic [N-1:0]  xdata;
    logic          xint;
    logic          busy;
    logic [2:0]    count;
`ifdef EXT_FEEDER_ECHO_EN
    logic [N-1:0]  result;
    logic [N-1:0]  echo;
    logic          echo_valid;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int            cyc = 0;
    int            ecnt = 0;
    int            etime [64];
    logic [N-1:0]  edata [64];
    logic          prev_int = 1'b0;
    int            e0;

    always #5 clk = ~clk;

    ext_feeder #(
        .N        (16),
        .DEPTH    (4),
        .PULSE_LEN(2),
        .GAP      (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .host_data_i (hd),
        .host_valid_i(hv),
        .host_ready_o(ready),
        .halt_i      (halt),
        .ext_data_o  (xdata),
        .ext_int_o   (xint),
        .busy_o      (busy),
        .count_o     (count)
`ifdef EXT_FEEDER_ECHO_EN
        ,
        .result_i    (result),
        .echo_o      (echo),
        .echo_valid_o(echo_valid)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Log every rising edge of ext_int_o with its cycle and the word presented.
    always @(negedge clk) begin
        if (xint && !prev_int && ecnt < 64) begin
            etime[ecnt] = cyc;
            edata[ecnt] = xdata;
            ecnt = ecnt + 1;
        end
        prev_int = xint;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        hd   = '0;
        hv   = 1'b0;
        halt = 1'b0;
`ifdef EXT_FEEDER_ECHO_EN
        result = '0;
`endif
        tick();
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_int", 32'(xint), 0);
        chk("rst_data", 32'(xdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(ready), 0);
`ifdef EXT_FEEDER_ECHO_EN
        chk("rst_echo", 32'(echo), 0);
        chk("rst_echo_valid", 32'(echo_valid), 0);
`endif
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(ready), 1);

        // Single word 0x00A5: IDLE, SETUP, 2 pulse cycles, 8 hold cycles.
        hd = 16'h00A5;
        hv = 1'b1;
        tick();
        hv = 1'b0;
        chk("t1_count_push", 32'(count), 1);
        chk("t1_idle_busy", 32'(busy), 0);
        tick();
        chk("t1_setup_busy", 32'(busy), 1);
        chk("t1_setup_data", 32'(xdata), 32'h00A5);
        chk("t1_setup_int", 32'(xint), 0);
        tick();
        chk("t1_pulse0", 32'(xint), 1);
        tick();
        chk("t1_pulse1", 32'(xint), 1);
        tick();
        chk("t1_hold0", 32'(xint), 0);
        chk("t1_hold_busy", 32'(busy), 1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("t1_hold_int", 32'(xint), 0);
        end
        chk("t1_count_last_hold", 32'(count), 1);
        tick();
        chk("t1_count_pop", 32'(count), 0);
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_data_kept", 32'(xdata), 32'h00A5);

        // Five back-to-back pushes into a 4-deep FIFO.
        e0 = ecnt;
        hv = 1'b1;
        hd = 16'h0001;
        tick();
        hd = 16'h0002;
        tick();
        hd = 16'h0003;
        tick();
        hd = 16'h0004;
        tick();
        chk("t2_full_ready", 32'(ready), 0);
        chk("t2_full_count", 32'(count), 4);
        hd = 16'h0005;
        repeat (9) tick();
        chk("t2_first_pop_count", 32'(count), 3);
        chk("t2_first_pop_ready", 32'(ready), 1);
        chk("t2_first_pop_busy", 32'(busy), 0);
        tick();
        chk("t2_fifth_push_count", 32'(count), 4);
        chk("t2_word2_data", 32'(xdata), 2);
        chk("t2_fifth_ready", 32'(ready), 0);
        hv = 1'b0;
        repeat (47) tick();
        chk("t2_drained_count", 32'(count), 0);
        chk("t2_drained_busy", 32'(busy), 0);
        chk("t2_last_data", 32'(xdata), 5);
        chk("t2_edge_count", 32'(ecnt - e0), 5);
        for (int k = 0; k < 5; k++) begin
            chk("t2_edge_data", 32'(edata[e0 + k]), 32'(k + 1));
        end
        for (int k = 1; k < 5; k++) begin
            chk("t2_edge_spacing", 32'(etime[e0 + k] - etime[e0 + k - 1]), 12);
        end

        // Halted before push: word stays queued until halt drops.
        e0 = ecnt;
        halt = 1'b1;
        hd = 16'h1234;
        hv = 1'b1;
        tick();
        hv = 1'b0;
        repeat (5) tick();
        chk("t3_halt_count", 32'(count), 1);
        chk("t3_halt_int", 32'(xint), 0);
        chk("t3_halt_busy", 32'(busy), 0);
        chk("t3_halt_no_edge", 32'(ecnt - e0), 0);
        halt = 1'b0;
        tick();
        chk("t3_start_busy", 32'(busy), 1);
        chk("t3_start_data", 32'(xdata), 32'h1234);
        repeat (11) tick();
        chk("t3_done_count", 32'(count), 0);
        chk("t3_done_busy", 32'(busy), 0);

        // Halt raised mid-pulse: delivery completes, next word waits.
        hd = 16'h0BEE;
        hv = 1'b1;
        tick();
        hd = 16'h0C0F;
        tick();
        hv = 1'b0;
        chk("t4_setup_data", 32'(xdata), 32'h0BEE);
        tick();
        halt = 1'b1;
        chk("t4_pulse", 32'(xint), 1);
        repeat (10) tick();
        chk("t4_pop_count", 32'(count), 1);
        chk("t4_pop_busy", 32'(busy), 0);
        repeat (3) tick();
        chk("t4_wait_busy", 32'(busy), 0);
        chk("t4_wait_count", 32'(count), 1);
        chk("t4_wait_data", 32'(xdata), 32'h0BEE);
        halt = 1'b0;
        tick();
        chk("t4_resume_busy", 32'(busy), 1);
        chk("t4_resume_data", 32'(xdata), 32'h0C0F);
        repeat (11) tick();
        chk("t4_done_count", 32'(count), 0);

        // Reset during HOLD with three words queued.
        hv = 1'b1;
        hd = 16'h0011;
        tick();
        hd = 16'h0022;
        tick();
        hd = 16'h0033;
        tick();
        hv = 1'b0;
        tick();
        tick();
        chk("t5_hold_busy", 32'(busy), 1);
        chk("t5_hold_count", 32'(count), 3);
        rst = 1'b1;
        tick();
        chk("t5_rst_count", 32'(count), 0);
        chk("t5_rst_int", 32'(xint), 0);
        chk("t5_rst_data", 32'(xdata), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_ready", 32'(ready), 0);
        rst = 1'b0;
        tick();
        chk("t5_release_ready", 32'(ready), 1);
        chk("t5_release_busy", 32'(busy), 0);

`ifdef EXT_FEEDER_ECHO_EN
        // Echo capture on the final HOLD cycle.
        hd = 16'h5A5A;
        hv = 1'b1;
        tick();
        hv = 1'b0;
        repeat (11) tick();
        chk("t6_echo_valid_before", 32'(echo_valid), 0);
        result = 16'h7FFF;
        tick();
        result = '0;
        chk("t6_echo", 32'(echo), 32'h7FFF);
        chk("t6_echo_valid", 32'(echo_valid), 1);
        chk("t6_pop_count", 32'(count), 0);
        tick();
        chk("t6_echo_valid_drop", 32'(echo_valid), 0);
        chk("t6_echo_hold", 32'(echo), 32'h7FFF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
